// File: rtl/rob_mc_if.sv
// rtl/rob_mc_if.sv - dispatch, writeback and commit bundle for rob_mc
// Purpose: groups the enqueue handshake, the CDB writeback channels and the
//   commit/flush/status outputs of the reorder buffer.
// Modports: slave = the reorder buffer itself, master = dispatch/CDB/commit side.
interface rob_mc_if #(
  parameter int DEPTH    = 32,
  parameter int WB_PORTS = 4,
  parameter int COMMIT_W = 2,
  parameter int DATA_W   = 32
);
  localparam int IDX_W = $clog2(DEPTH);

  logic                         enq_valid;
  logic                         enq_ready;
  logic [31:0]                  enq_pc;
  logic [4:0]                   enq_rd_addr;
  logic                         enq_regf_we;
  logic [IDX_W-1:0]             enq_idx;

  logic [WB_PORTS-1:0]          wb_valid;
  logic [WB_PORTS*IDX_W-1:0]    wb_idx;
  logic [WB_PORTS*DATA_W-1:0]   wb_data;
  logic [WB_PORTS-1:0]          wb_mispredict;
  logic [WB_PORTS*32-1:0]       wb_pc_new;

  logic [COMMIT_W-1:0]          commit_valid;
  logic [COMMIT_W*32-1:0]       commit_pc;
  logic [COMMIT_W*5-1:0]        commit_rd_addr;
  logic [COMMIT_W*DATA_W-1:0]   commit_data;
  logic [COMMIT_W-1:0]          commit_regf_we;

  logic                         flush_o;
  logic [31:0]                  flush_pc_o;
  logic [IDX_W:0]               count_o;
  logic                         empty_o;
  logic                         full_o;

  modport slave (
    input  enq_valid, enq_pc, enq_rd_addr, enq_regf_we,
    input  wb_valid, wb_idx, wb_data, wb_mispredict, wb_pc_new,
    output enq_ready, enq_idx,
    output commit_valid, commit_pc, commit_rd_addr, commit_data, commit_regf_we,
    output flush_o, flush_pc_o, count_o, empty_o, full_o
  );

  modport master (
    output enq_valid, enq_pc, enq_rd_addr, enq_regf_we,
    output wb_valid, wb_idx, wb_data, wb_mispredict, wb_pc_new,
    input  enq_ready, enq_idx,
    input  commit_valid, commit_pc, commit_rd_addr, commit_data, commit_regf_we,
    input  flush_o, flush_pc_o, count_o, empty_o, full_o
  );
endinterface

// File: rtl/rob_mc.sv
// rtl/rob_mc.sv - multi-commit reorder buffer with mispredict flush
// Purpose: allocates entries in program order, takes out-of-order CDB
//   writeback, retires up to COMMIT_W done entries per cycle in order and
//   flushes everything younger than a retiring mispredicted branch.
// Ports: clk, rst_n (async active-low), bus (rob_mc_if.slave: enqueue
//   handshake, WB_PORTS writeback channels, COMMIT_W commit lanes,
//   flush/redirect and occupancy status).
module rob_mc #(
  parameter int DEPTH    = 32,
  parameter int WB_PORTS = 4,
  parameter int COMMIT_W = 2,
  parameter int DATA_W   = 32
) (
  input  logic    clk,
  input  logic    rst_n,
  rob_mc_if.slave bus
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [IDX_W-1:0] IDX_ONE  = 1;
  localparam logic [IDX_W:0]   CNT_ONE  = 1;
  localparam logic [IDX_W:0]   CNT_FULL = (IDX_W+1)'(DEPTH);

  logic [DEPTH-1:0]  r_valid, r_done, r_mis;
  logic [31:0]       r_pc    [DEPTH];
  logic [4:0]        r_rd    [DEPTH];
  logic              r_we    [DEPTH];
  logic [DATA_W-1:0] r_data  [DEPTH];
  logic [31:0]       r_pcnew [DEPTH];
  logic [IDX_W-1:0]  r_head, r_tail;
  logic [IDX_W:0]    r_count;

  logic [IDX_W-1:0]    w_lane_idx [COMMIT_W];
  logic [IDX_W-1:0]    w_wb_idx   [WB_PORTS];
  logic [COMMIT_W-1:0] w_cvalid;
  logic [IDX_W:0]      w_n;
  logic                w_chain;
  logic                w_flush;
  logic [31:0]         w_flush_pc;
  logic                w_full;
  logic                w_fire;

  always_comb begin
    for (int k = 0; k < COMMIT_W; k++) w_lane_idx[k] = r_head + IDX_W'(k);
    for (int p = 0; p < WB_PORTS; p++) w_wb_idx[p] = bus.wb_idx[p*IDX_W +: IDX_W];
  end

  // Lane k retires only if every older lane retires and none of them is a
  // mispredict; a mispredicting entry therefore always ends the commit group.
  always_comb begin
    w_cvalid       = '0;
    w_n            = '0;
    w_chain        = 1'b1;
    w_flush        = 1'b0;
    w_flush_pc     = '0;
    bus.commit_pc      = '0;
    bus.commit_rd_addr = '0;
    bus.commit_data    = '0;
    bus.commit_regf_we = '0;
    for (int k = 0; k < COMMIT_W; k++) begin
      bus.commit_pc[k*32 +: 32]         = r_pc[w_lane_idx[k]];
      bus.commit_rd_addr[k*5 +: 5]      = r_rd[w_lane_idx[k]];
      bus.commit_data[k*DATA_W +: DATA_W] = r_data[w_lane_idx[k]];
      bus.commit_regf_we[k]             = r_we[w_lane_idx[k]];
      if (w_chain && r_valid[w_lane_idx[k]] && r_done[w_lane_idx[k]]) begin
        w_cvalid[k] = 1'b1;
        w_n         = w_n + CNT_ONE;
        if (r_mis[w_lane_idx[k]]) begin
          w_flush    = 1'b1;
          w_flush_pc = r_pcnew[w_lane_idx[k]];
        end
      end
      w_chain = w_cvalid[k] && !r_mis[w_lane_idx[k]];
    end
  end

  // Full is judged on the registered count, so a same-cycle commit never
  // makes room for an enqueue.
  assign w_full           = (r_count == CNT_FULL);
  assign w_fire           = bus.enq_valid && bus.enq_ready;
  assign bus.enq_ready    = !w_full && !w_flush;
  assign bus.enq_idx      = r_tail;
  assign bus.commit_valid = w_cvalid;
  assign bus.flush_o      = w_flush;
  assign bus.flush_pc_o   = w_flush_pc;
  assign bus.count_o      = r_count;
  assign bus.empty_o      = (r_count == '0);
  assign bus.full_o       = w_full;

  // Update order matters: writeback, then commit clear, then allocation, so
  // the later assignment wins when they touch the same entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      r_done  <= '0;
      r_mis   <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (w_flush) begin
      r_valid <= '0;
      r_done  <= '0;
      r_head  <= r_head + w_n[IDX_W-1:0];
      r_tail  <= r_head + w_n[IDX_W-1:0];
      r_count <= '0;
    end else begin
      for (int p = 0; p < WB_PORTS; p++) begin
        if (bus.wb_valid[p] && r_valid[w_wb_idx[p]]) begin
          r_done[w_wb_idx[p]] <= 1'b1;
          r_mis[w_wb_idx[p]]  <= bus.wb_mispredict[p];
        end
      end
      for (int k = 0; k < COMMIT_W; k++) begin
        if (w_cvalid[k]) begin
          r_valid[w_lane_idx[k]] <= 1'b0;
          r_done[w_lane_idx[k]]  <= 1'b0;
        end
      end
      if (w_fire) begin
        r_valid[r_tail] <= 1'b1;
        r_done[r_tail]  <= 1'b0;
        r_mis[r_tail]   <= 1'b0;
        r_tail          <= r_tail + IDX_ONE;
      end
      r_head  <= r_head + w_n[IDX_W-1:0];
      r_count <= r_count + (w_fire ? CNT_ONE : '0) - w_n;
    end
  end

  // Payload needs no reset: it is only observed through valid entries.
  always_ff @(posedge clk) begin
    for (int p = 0; p < WB_PORTS; p++) begin
      if (bus.wb_valid[p] && r_valid[w_wb_idx[p]] && !w_flush) begin
        r_data[w_wb_idx[p]]  <= bus.wb_data[p*DATA_W +: DATA_W];
        r_pcnew[w_wb_idx[p]] <= bus.wb_pc_new[p*32 +: 32];
      end
    end
    if (w_fire) begin
      r_pc[r_tail] <= bus.enq_pc;
      r_rd[r_tail] <= bus.enq_rd_addr;
      r_we[r_tail] <= bus.enq_regf_we;
    end
  end
endmodule

// File: tb/tb_rob_mc.sv
// tb/tb_rob_mc.sv - scoreboard bench for rob_mc
module tb_rob_mc;
  localparam int DEPTH = 32, WB_PORTS = 4, COMMIT_W = 2, DATA_W = 32;
  localparam int IDX_W = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rob_mc_if #(.DEPTH(DEPTH), .WB_PORTS(WB_PORTS), .COMMIT_W(COMMIT_W), .DATA_W(DATA_W)) bus ();
  rob_mc #(.DEPTH(DEPTH), .WB_PORTS(WB_PORTS), .COMMIT_W(COMMIT_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_pc[$], exp_data[$], got_pc[$], got_data[$];
  int          last_n;
  logic        last_flush, last_enq_ready;
  logic [31:0] last_flush_pc;
  logic [IDX_W-1:0] last_idx;

  // Sample commit lanes mid-cycle, then advance to just after the next edge.
  task automatic tick();
    @(negedge clk);
    last_n = 0;
    last_flush = bus.flush_o;
    last_flush_pc = bus.flush_pc_o;
    last_enq_ready = bus.enq_ready;
    for (int k = 0; k < COMMIT_W; k++) begin
      if (bus.commit_valid[k]) begin
        got_pc.push_back(bus.commit_pc[k*32 +: 32]);
        got_data.push_back(bus.commit_data[k*DATA_W +: DATA_W]);
        last_n++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic sb_clear();
    exp_pc.delete(); exp_data.delete(); got_pc.delete(); got_data.delete();
  endtask

  task automatic enq(input logic [31:0] pc, input logic [4:0] rd);
    bus.enq_valid = 1'b1; bus.enq_pc = pc; bus.enq_rd_addr = rd; bus.enq_regf_we = 1'b1;
    last_idx = bus.enq_idx;
    tick();
    bus.enq_valid = 1'b0;
  endtask

  task automatic wb_set(input int p, input int idx, input logic [31:0] d, input logic mis, input logic [31:0] pcn);
    logic [IDX_W-1:0] i5;
    i5 = IDX_W'(idx);
    bus.wb_valid[p] = 1'b1;
    bus.wb_idx[p*IDX_W +: IDX_W] = i5;
    bus.wb_data[p*DATA_W +: DATA_W] = d;
    bus.wb_mispredict[p] = mis;
    bus.wb_pc_new[p*32 +: 32] = pcn;
  endtask

  task automatic wb_clear();
    bus.wb_valid = '0; bus.wb_idx = '0; bus.wb_data = '0; bus.wb_mispredict = '0; bus.wb_pc_new = '0;
  endtask

  task automatic drain(input int max, output bit timed_out);
    timed_out = 1'b1;
    for (int i = 0; i < max; i++) begin
      if (bus.empty_o) begin timed_out = 1'b0; break; end
      tick();
    end
    if (bus.empty_o) timed_out = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    checks++; if (bus.enq_idx !== 5'd0) begin errors++; $display("FAIL reset_enq_idx got %0d exp 0", bus.enq_idx); end
    checks++; if (bus.flush_o !== 1'b0 || bus.flush_pc_o !== 32'h0) begin errors++; $display("FAIL reset_flush got %b/%h exp 0/0", bus.flush_o, bus.flush_pc_o); end
    checks++; if (bus.full_o !== 1'b0) begin errors++; $display("FAIL reset_full got %b exp 0", bus.full_o); end
    for (int c = 0; c < 10; c++) begin
      tick();
      checks++; if (bus.enq_ready !== 1'b1 || bus.empty_o !== 1'b1) begin errors++; $display("FAIL idle_ready_empty cyc %0d got %b/%b exp 1/1", c, bus.enq_ready, bus.empty_o); end
      checks++; if (bus.count_o !== 6'd0) begin errors++; $display("FAIL idle_count cyc %0d got %0d exp 0", c, bus.count_o); end
      checks++; if (bus.commit_valid !== 2'b00 || last_n !== 0) begin errors++; $display("FAIL idle_commit cyc %0d got %b exp 00", c, bus.commit_valid); end
    end
  endtask

  task automatic test_fill_drain();
    bit to;
    sb_clear();
    for (int i = 0; i < 32; i++) begin
      logic [31:0] pc;
      pc = 32'h1000 + 32'(4*i);
      exp_pc.push_back(pc); exp_data.push_back(pc ^ 32'h5A5A_0000);
      checks++; if (bus.enq_ready !== 1'b1) begin errors++; $display("FAIL fill_ready i %0d got %b exp 1", i, bus.enq_ready); end
      enq(pc, 5'(i));
      checks++; if (last_idx !== 5'(i)) begin errors++; $display("FAIL fill_idx got %0d exp %0d", last_idx, i); end
    end
    checks++; if (bus.full_o !== 1'b1 || bus.enq_ready !== 1'b0) begin errors++; $display("FAIL full_flags got full %b ready %b exp 1/0", bus.full_o, bus.enq_ready); end
    checks++; if (bus.count_o !== 6'd32) begin errors++; $display("FAIL full_count got %0d exp 32", bus.count_o); end
    for (int i = 31; i >= 0; i--) begin
      wb_set(0, i, (32'h1000 + 32'(4*i)) ^ 32'h5A5A_0000, 1'b0, 32'h0);
      tick();
      wb_clear();
    end
    checks++; if (got_pc.size() !== 0) begin errors++; $display("FAIL early_commit got %0d commits exp 0", got_pc.size()); end
    for (int c = 0; c < 16; c++) begin
      tick();
      checks++; if (last_n !== 2) begin errors++; $display("FAIL drain_rate cyc %0d got %0d exp 2", c, last_n); end
    end
    checks++; if (bus.empty_o !== 1'b1) begin errors++; $display("FAIL drain_empty got %b exp 1", bus.empty_o); end
    drain(4, to);
    checks++; if (got_pc.size() !== exp_pc.size()) begin errors++; $display("FAIL fill_sb_count got %0d exp %0d", got_pc.size(), exp_pc.size()); end
    while (got_pc.size() > 0 && exp_pc.size() > 0) begin
      logic [31:0] gp, gd, ep, ed;
      gp = got_pc.pop_front(); gd = got_data.pop_front(); ep = exp_pc.pop_front(); ed = exp_data.pop_front();
      checks++; if (gp !== ep || gd !== ed) begin errors++; $display("FAIL fill_sb got %h/%h exp %h/%h", gp, gd, ep, ed); end
    end
  endtask

  task automatic test_port_conflict();
    bit to;
    sb_clear();
    for (int i = 0; i < 6; i++) begin
      enq(32'h2000 + 32'(4*i), 5'(i));
      exp_pc.push_back(32'h2000 + 32'(4*i));
      exp_data.push_back(i == 5 ? 32'h5555 : 32'h1100 + 32'(i));
    end
    for (int p = 0; p < 4; p++) wb_set(p, p, 32'h1100 + 32'(p), 1'b0, 32'h0);
    tick(); wb_clear();
    wb_set(1, 4, 32'h1104, 1'b0, 32'h0);
    wb_set(0, 5, 32'hAAAA, 1'b0, 32'h0);
    wb_set(3, 5, 32'h5555, 1'b0, 32'h0);
    tick(); wb_clear();
    drain(20, to);
    checks++; if (to) begin errors++; $display("FAIL conflict_drain_timeout got count %0d exp 0", bus.count_o); end
    checks++; if (got_pc.size() !== exp_pc.size()) begin errors++; $display("FAIL conflict_sb_count got %0d exp %0d", got_pc.size(), exp_pc.size()); end
    while (got_pc.size() > 0 && exp_pc.size() > 0) begin
      logic [31:0] gp, gd, ep, ed;
      gp = got_pc.pop_front(); gd = got_data.pop_front(); ep = exp_pc.pop_front(); ed = exp_data.pop_front();
      checks++; if (gp !== ep || gd !== ed) begin errors++; $display("FAIL conflict_sb got %h/%h exp %h/%h", gp, gd, ep, ed); end
    end
  endtask

  task automatic test_mispredict();
    sb_clear();
    // head = tail = 6 here
    for (int i = 0; i < 6; i++) enq(32'h3000 + 32'(4*i), 5'(i));
    exp_pc.push_back(32'h3000); exp_data.push_back(32'h3300);
    exp_pc.push_back(32'h3004); exp_data.push_back(32'h3301);
    wb_set(0, 7, 32'h3301, 1'b1, 32'h8000_0040);
    wb_set(1, 8, 32'h3302, 1'b0, 32'h0);
    wb_set(2, 9, 32'h3303, 1'b0, 32'h0);
    wb_set(3, 10, 32'h3304, 1'b0, 32'h0);
    tick(); wb_clear();
    wb_set(0, 11, 32'h3305, 1'b0, 32'h0);
    wb_set(1, 6, 32'h3300, 1'b0, 32'h0);
    tick(); wb_clear();
    tick();
    checks++; if (last_n !== 2) begin errors++; $display("FAIL flush_lanes got %0d exp 2", last_n); end
    checks++; if (last_flush !== 1'b1 || last_flush_pc !== 32'h8000_0040) begin errors++; $display("FAIL flush_pc got %b/%h exp 1/80000040", last_flush, last_flush_pc); end
    checks++; if (last_enq_ready !== 1'b0) begin errors++; $display("FAIL flush_enq_ready got %b exp 0", last_enq_ready); end
    checks++; if (bus.count_o !== 6'd0) begin errors++; $display("FAIL flush_count got %0d exp 0", bus.count_o); end
    checks++; if (bus.enq_idx !== 5'd8) begin errors++; $display("FAIL flush_tail got %0d exp 8", bus.enq_idx); end
    repeat (5) tick();
    checks++; if (last_flush !== 1'b0) begin errors++; $display("FAIL flush_clear got %b exp 0", last_flush); end
    checks++; if (got_pc.size() !== exp_pc.size()) begin errors++; $display("FAIL flush_sb_count got %0d exp %0d", got_pc.size(), exp_pc.size()); end
    while (got_pc.size() > 0 && exp_pc.size() > 0) begin
      logic [31:0] gp, gd, ep, ed;
      gp = got_pc.pop_front(); gd = got_data.pop_front(); ep = exp_pc.pop_front(); ed = exp_data.pop_front();
      checks++; if (gp !== ep || gd !== ed) begin errors++; $display("FAIL flush_sb got %h/%h exp %h/%h", gp, gd, ep, ed); end
    end
  endtask

  task automatic test_wrap();
    bit to;
    sb_clear();
    for (int i = 0; i < 23; i++) begin
      enq(32'h4000 + 32'(4*i), 5'(i));
      exp_pc.push_back(32'h4000 + 32'(4*i)); exp_data.push_back(32'h4400 + 32'(i));
    end
    for (int b = 0; b < 23; b += 4) begin
      for (int p = 0; p < 4; p++) if (b + p < 23) wb_set(p, 8 + b + p, 32'h4400 + 32'(b + p), 1'b0, 32'h0);
      tick(); wb_clear();
    end
    drain(40, to);
    checks++; if (to || bus.enq_idx !== 5'd31) begin errors++; $display("FAIL wrap_pre got tail %0d exp 31", bus.enq_idx); end
    for (int i = 0; i < 3; i++) begin
      enq(32'h5000 + 32'(4*i), 5'(i));
      exp_pc.push_back(32'h5000 + 32'(4*i)); exp_data.push_back(32'h5500 + 32'(i));
    end
    wb_set(0, 31, 32'h5500, 1'b0, 32'h0);
    wb_set(1, 0, 32'h5501, 1'b0, 32'h0);
    wb_set(2, 1, 32'h5502, 1'b0, 32'h0);
    tick(); wb_clear();
    tick();
    checks++; if (last_n !== 2) begin errors++; $display("FAIL wrap_pair got %0d exp 2", last_n); end
    tick();
    checks++; if (last_n !== 1) begin errors++; $display("FAIL wrap_single got %0d exp 1", last_n); end
    checks++; if (bus.empty_o !== 1'b1) begin errors++; $display("FAIL wrap_empty got %b exp 1", bus.empty_o); end
    checks++; if (got_pc.size() !== exp_pc.size()) begin errors++; $display("FAIL wrap_sb_count got %0d exp %0d", got_pc.size(), exp_pc.size()); end
    while (got_pc.size() > 0 && exp_pc.size() > 0) begin
      logic [31:0] gp, gd, ep, ed;
      gp = got_pc.pop_front(); gd = got_data.pop_front(); ep = exp_pc.pop_front(); ed = exp_data.pop_front();
      checks++; if (gp !== ep || gd !== ed) begin errors++; $display("FAIL wrap_sb got %h/%h exp %h/%h", gp, gd, ep, ed); end
    end
  endtask

  task automatic test_async_reset();
    sb_clear();
    for (int i = 0; i < 10; i++) enq(32'h6000 + 32'(4*i), 5'(i));
    checks++; if (bus.count_o !== 6'd10) begin errors++; $display("FAIL pre_reset_count got %0d exp 10", bus.count_o); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.count_o !== 6'd0 || bus.empty_o !== 1'b1 || bus.full_o !== 1'b0) begin errors++; $display("FAIL async_status got %0d/%b/%b exp 0/1/0", bus.count_o, bus.empty_o, bus.full_o); end
    checks++; if (bus.enq_ready !== 1'b1 || bus.enq_idx !== 5'd0) begin errors++; $display("FAIL async_enq got %b/%0d exp 1/0", bus.enq_ready, bus.enq_idx); end
    checks++; if (bus.commit_valid !== 2'b00 || bus.flush_o !== 1'b0) begin errors++; $display("FAIL async_commit got %b/%b exp 00/0", bus.commit_valid, bus.flush_o); end
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    wb_set(0, 3, 32'hDEAD, 1'b0, 32'h0);
    tick(); wb_clear();
    repeat (3) tick();
    checks++; if (got_pc.size() !== 0 || bus.count_o !== 6'd0) begin errors++; $display("FAIL late_wb got %0d commits count %0d exp 0/0", got_pc.size(), bus.count_o); end
    for (int i = 0; i < 4; i++) begin
      enq(32'h7000 + 32'(4*i), 5'(i));
      if (i < 3) begin exp_pc.push_back(32'h7000 + 32'(4*i)); exp_data.push_back(32'h7700 + 32'(i)); end
    end
    for (int p = 0; p < 3; p++) wb_set(p, p, 32'h7700 + 32'(p), 1'b0, 32'h0);
    tick(); wb_clear();
    repeat (4) tick();
    checks++; if (bus.count_o !== 6'd1) begin errors++; $display("FAIL post_reset_count got %0d exp 1", bus.count_o); end
    checks++; if (got_pc.size() !== exp_pc.size()) begin errors++; $display("FAIL post_reset_sb_count got %0d exp %0d", got_pc.size(), exp_pc.size()); end
    while (got_pc.size() > 0 && exp_pc.size() > 0) begin
      logic [31:0] gp, gd, ep, ed;
      gp = got_pc.pop_front(); gd = got_data.pop_front(); ep = exp_pc.pop_front(); ed = exp_data.pop_front();
      checks++; if (gp !== ep || gd !== ed) begin errors++; $display("FAIL post_reset_sb got %h/%h exp %h/%h", gp, gd, ep, ed); end
    end
  endtask

  initial begin
    bus.enq_valid = 1'b0; bus.enq_pc = '0; bus.enq_rd_addr = '0; bus.enq_regf_we = 1'b0;
    wb_clear();
    test_reset();
    test_fill_drain();
    test_port_conflict();
    test_mispredict();
    test_wrap();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end
endmodule
